// File: rtl/memy_port_ctrl_pkg.sv
// Shared widths and priority-state type for the memory-Y port controller.
package memy_port_ctrl_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int MEM_DEPTH = 256;

    typedef enum logic {
        PRI_X = 1'b0,
        PRI_Y = 1'b1
    } pri_e;

    function automatic pri_e other_port(input pri_e p);
        return (p == PRI_X) ? PRI_Y : PRI_X;
    endfunction

endpackage

// File: rtl/memy_port_ctrl_pipe.sv
// One RAM port: registers an accepted command onto the RAM pins and tracks
// outstanding reads so rvalid lines up with the RAM's registered read data.
module memy_port_pipe
    import memy_port_ctrl_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          accept,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_q,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);

    logic rd_pend;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
            rd_pend  <= 1'b0;
            rvalid   <= 1'b0;
        end else begin
            ram_we  <= accept & we;
            rd_pend <= accept & ~we;
            rvalid  <= rd_pend;
            // Address holds while idle so the RAM just re-reads harmlessly.
            if (accept) begin
                ram_addr <= addr;
                ram_data <= wdata;
            end
        end
    end

    assign rdata = ram_q;

endmodule

// File: rtl/memy_port_ctrl.sv
// Dual-client front end for dualram: grants X/Y requests, serialises
// same-address hazards with an alternating priority, and returns read data.
module memy_port_ctrl
    import memy_port_ctrl_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          x_req,
    input  logic          x_we,
    input  logic [AW-1:0] x_addr,
    input  logic [DW-1:0] x_wdata,
    output logic          x_gnt,
    output logic          x_rvalid,
    output logic [DW-1:0] x_rdata,
    input  logic          y_req,
    input  logic          y_we,
    input  logic [AW-1:0] y_addr,
    input  logic [DW-1:0] y_wdata,
    output logic          y_gnt,
    output logic          y_rvalid,
    output logic [DW-1:0] y_rdata,
    output logic          ram_we_x,
    output logic [AW-1:0] ram_addr_x,
    output logic [DW-1:0] ram_data_x,
    input  logic [DW-1:0] ram_q_x,
    output logic          ram_we_y,
    output logic [AW-1:0] ram_addr_y,
    output logic [DW-1:0] ram_data_y,
    input  logic [DW-1:0] ram_q_y
);

    pri_e pri, pri_nxt;
    logic conflict;

    // Two reads of one address are safe; any write involvement is a hazard.
    assign conflict = x_req && y_req && (x_addr == y_addr) && (x_we || y_we);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pri <= PRI_X;
        else     pri <= pri_nxt;
    end

    // NOTE: every output of this block is given a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        x_gnt   = 1'b0;
        y_gnt   = 1'b0;
        pri_nxt = pri;
        if (!rst) begin
            x_gnt = x_req && (!conflict || pri == PRI_X);
            y_gnt = y_req && (!conflict || pri == PRI_Y);
            // The loser of this conflict wins the next one.
            if (conflict) pri_nxt = other_port(pri);
        end
    end

    memy_port_pipe #(.DW(DW), .AW(AW)) u_pipe_x (
        .clk      (clk),
        .rst      (rst),
        .accept   (x_gnt),
        .we       (x_we),
        .addr     (x_addr),
        .wdata    (x_wdata),
        .ram_we   (ram_we_x),
        .ram_addr (ram_addr_x),
        .ram_data (ram_data_x),
        .ram_q    (ram_q_x),
        .rvalid   (x_rvalid),
        .rdata    (x_rdata)
    );

    memy_port_pipe #(.DW(DW), .AW(AW)) u_pipe_y (
        .clk      (clk),
        .rst      (rst),
        .accept   (y_gnt),
        .we       (y_we),
        .addr     (y_addr),
        .wdata    (y_wdata),
        .ram_we   (ram_we_y),
        .ram_addr (ram_addr_y),
        .ram_data (ram_data_y),
        .ram_q    (ram_q_y),
        .rvalid   (y_rvalid),
        .rdata    (y_rdata)
    );

endmodule

// File: tb/tb_memy_port_ctrl.sv
// Bench for memy_port_ctrl with a behavioural dual-port RAM behind it.
module tb_memy_port_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;
    localparam int IW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          x_req, x_we, y_req, y_we;
    logic [AW-1:0] x_addr, y_addr;
    logic [DW-1:0] x_wdata, y_wdata;
    logic          x_gnt, y_gnt, x_rvalid, y_rvalid;
    logic [DW-1:0] x_rdata, y_rdata;
    logic          ram_we_x, ram_we_y;
    logic [AW-1:0] ram_addr_x, ram_addr_y;
    logic [DW-1:0] ram_data_x, ram_data_y;
    logic [DW-1:0] ram_q_x, ram_q_y;

    always #5 clk = ~clk;

    memy_port_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .x_req      (x_req),
        .x_we       (x_we),
        .x_addr     (x_addr),
        .x_wdata    (x_wdata),
        .x_gnt      (x_gnt),
        .x_rvalid   (x_rvalid),
        .x_rdata    (x_rdata),
        .y_req      (y_req),
        .y_we       (y_we),
        .y_addr     (y_addr),
        .y_wdata    (y_wdata),
        .y_gnt      (y_gnt),
        .y_rvalid   (y_rvalid),
        .y_rdata    (y_rdata),
        .ram_we_x   (ram_we_x),
        .ram_addr_x (ram_addr_x),
        .ram_data_x (ram_data_x),
        .ram_q_x    (ram_q_x),
        .ram_we_y   (ram_we_y),
        .ram_addr_y (ram_addr_y),
        .ram_data_y (ram_data_y),
        .ram_q_y    (ram_q_y)
    );

    // Behavioural dualram: synchronous write, registered read data.
    logic [DW-1:0] mem [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (ram_we_x === 1'b1) mem[ram_addr_x[IW-1:0]] <= ram_data_x;
        if (ram_we_y === 1'b1) mem[ram_addr_y[IW-1:0]] <= ram_data_y;
        ram_q_x <= mem[ram_addr_x[IW-1:0]];
        ram_q_y <= mem[ram_addr_y[IW-1:0]];
    end

    // Reference model: memory image, priority holder, expected read responses.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } resp_t;

    logic [DW-1:0] ref_mem [DEPTH] = '{default: '0};
    logic          ref_pri_y;
    resp_t         qx[$];
    resp_t         qy[$];
    int            sample;
    int            n_checks;
    int            n_pass;

    typedef struct {
        logic          xr, xw;
        logic [AW-1:0] xa;
        logic [DW-1:0] xd;
        logic          yr, yw;
        logic [AW-1:0] ya;
        logic [DW-1:0] yd;
        logic          exg, eyg;
        logic          exv;
        logic [DW-1:0] exd;
        logic          eyv;
        logic [DW-1:0] eyd;
    } vec_t;

    vec_t vecs[$];

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (sample %0d)", name, act, exp, sample);
    endtask

    task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (sample %0d)", name, act, exp, sample);
    endtask

    task automatic drive(input logic xr, input logic xw, input logic [AW-1:0] xa, input logic [DW-1:0] xd,
                         input logic yr, input logic yw, input logic [AW-1:0] ya, input logic [DW-1:0] yd);
        x_req = xr; x_we = xw; x_addr = xa; x_wdata = xd;
        y_req = yr; y_we = yw; y_addr = ya; y_wdata = yd;
    endtask

    function automatic vec_t mk(input logic xr, input logic xw, input logic [AW-1:0] xa, input logic [DW-1:0] xd,
                                input logic yr, input logic yw, input logic [AW-1:0] ya, input logic [DW-1:0] yd,
                                input logic exg, input logic eyg,
                                input logic exv, input logic [DW-1:0] exd,
                                input logic eyv, input logic [DW-1:0] eyd);
        vec_t v;
        v.xr = xr; v.xw = xw; v.xa = xa; v.xd = xd;
        v.yr = yr; v.yw = yw; v.ya = ya; v.yd = yd;
        v.exg = exg; v.eyg = eyg;
        v.exv = exv; v.exd = exd; v.eyv = eyv; v.eyd = eyd;
        return v;
    endfunction

    // Called mid-cycle with inputs stable: checks gnt and responses, then
    // applies accepted commands to the memory image in acceptance order.
    task automatic model_step();
        logic  conf, eg_x, eg_y;
        resp_t r;
        conf = x_req && y_req && (x_addr == y_addr) && (x_we || y_we);
        eg_x = x_req && (!conf || !ref_pri_y);
        eg_y = y_req && (!conf || ref_pri_y);
        check_bit("x_gnt", x_gnt, eg_x);
        check_bit("y_gnt", y_gnt, eg_y);

        if (qx.size() > 0 && qx[0].due == sample) begin
            check_bit("x_rvalid", x_rvalid, 1'b1);
            check_word("x_rdata", x_rdata, qx[0].data);
            void'(qx.pop_front());
        end else begin
            check_bit("x_rvalid_idle", x_rvalid, 1'b0);
        end
        if (qy.size() > 0 && qy[0].due == sample) begin
            check_bit("y_rvalid", y_rvalid, 1'b1);
            check_word("y_rdata", y_rdata, qy[0].data);
            void'(qy.pop_front());
        end else begin
            check_bit("y_rvalid_idle", y_rvalid, 1'b0);
        end

        if (eg_x && x_we) ref_mem[x_addr[IW-1:0]] = x_wdata;
        if (eg_y && y_we) ref_mem[y_addr[IW-1:0]] = y_wdata;
        if (eg_x && !x_we) begin
            r.due = sample + 2; r.data = ref_mem[x_addr[IW-1:0]]; qx.push_back(r);
        end
        if (eg_y && !y_we) begin
            r.due = sample + 2; r.data = ref_mem[y_addr[IW-1:0]]; qy.push_back(r);
        end
        if (conf) ref_pri_y = !ref_pri_y;
        sample++;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        sample    = 0;
        ref_pri_y = 1'b0;

        // Directed vectors; expected rvalid/rdata are for the same sample.
        vecs.push_back(mk(1,1,'h10,'hBEEF, 0,0,0,0,          1,0, 0,0,       0,0));
        vecs.push_back(mk(1,0,'h10,0,      0,0,0,0,          1,0, 0,0,       0,0));
        vecs.push_back(mk(1,0,'h20,0,      1,1,'h30,'h1234,  1,1, 0,0,       0,0));
        vecs.push_back(mk(0,0,0,0,         0,0,0,0,          0,0, 1,'hBEEF,  0,0));
        vecs.push_back(mk(0,0,0,0,         1,0,'h30,0,       0,1, 1,'h0000,  0,0));
        vecs.push_back(mk(1,1,'h40,'hAAAA, 1,0,'h40,0,       1,0, 0,0,       0,0));
        vecs.push_back(mk(0,0,0,0,         1,0,'h40,0,       0,1, 0,0,       1,'h1234));
        vecs.push_back(mk(0,0,0,0,         0,0,0,0,          0,0, 0,0,       0,0));
        vecs.push_back(mk(0,0,0,0,         0,0,0,0,          0,0, 0,0,       1,'hAAAA));
        vecs.push_back(mk(1,0,'h70,0,      1,1,'h70,'h5555,  0,1, 0,0,       0,0));
        vecs.push_back(mk(1,1,'h60,'h1111, 1,1,'h60,'h2222,  1,0, 0,0,       0,0));
        vecs.push_back(mk(1,1,'h60,'h3333, 1,1,'h60,'h4444,  0,1, 0,0,       0,0));
        vecs.push_back(mk(0,0,0,0,         0,0,0,0,          0,0, 0,0,       0,0));
        vecs.push_back(mk(1,0,'h60,0,      0,0,0,0,          1,0, 0,0,       0,0));
        vecs.push_back(mk(0,0,0,0,         0,0,0,0,          0,0, 0,0,       0,0));
        vecs.push_back(mk(0,0,0,0,         0,0,0,0,          0,0, 1,'h4444,  0,0));
        vecs.push_back(mk(1,0,'h50,0,      1,0,'h50,0,       1,1, 0,0,       0,0));
        vecs.push_back(mk(1,1,'h50,'h7777, 1,0,'h50,0,       1,0, 0,0,       0,0));
        vecs.push_back(mk(0,0,0,0,         0,0,0,0,          0,0, 1,'h0000,  1,'h0000));
        vecs.push_back(mk(0,0,0,0,         0,0,0,0,          0,0, 0,0,       0,0));

        // Reset state, with requests pending to show gnt is held low.
        rst = 1'b1;
        drive(1, 1, 'h5, 'h1, 1, 1, 'h5, 'h2);
        #12;
        check_bit("rst_x_gnt", x_gnt, 1'b0);
        check_bit("rst_y_gnt", y_gnt, 1'b0);
        check_bit("rst_ram_we_x", ram_we_x, 1'b0);
        check_bit("rst_ram_we_y", ram_we_y, 1'b0);
        check_word("rst_ram_addr_x", ram_addr_x, '0);
        check_word("rst_ram_data_y", ram_data_y, '0);
        check_bit("rst_x_rvalid", x_rvalid, 1'b0);
        check_bit("rst_y_rvalid", y_rvalid, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].xr, vecs[i].xw, vecs[i].xa, vecs[i].xd,
                  vecs[i].yr, vecs[i].yw, vecs[i].ya, vecs[i].yd);
            @(negedge clk);
            check_bit("tbl_x_gnt", x_gnt, vecs[i].exg);
            check_bit("tbl_y_gnt", y_gnt, vecs[i].eyg);
            check_bit("tbl_x_rvalid", x_rvalid, vecs[i].exv);
            check_bit("tbl_y_rvalid", y_rvalid, vecs[i].eyv);
            if (vecs[i].exv) check_word("tbl_x_rdata", x_rdata, vecs[i].exd);
            if (vecs[i].eyv) check_word("tbl_y_rdata", y_rdata, vecs[i].eyd);
            model_step();
            @(posedge clk);
            #1;
        end

        // Reset one cycle after a read is accepted: its response must vanish
        // and priority (currently with Y) must return to X.
        drive(1, 0, 'h10, 0, 0, 0, 0, 0);
        run_cycle();
        rst = 1'b1;
        drive(1, 1, 'h90, 'h0001, 1, 1, 'h90, 'h0002);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_bit("inrst_x_gnt", x_gnt, 1'b0);
            check_bit("inrst_y_gnt", y_gnt, 1'b0);
            check_bit("inrst_ram_we_x", ram_we_x, 1'b0);
            check_bit("inrst_ram_we_y", ram_we_y, 1'b0);
            check_bit("inrst_x_rvalid", x_rvalid, 1'b0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        qx.delete();
        qy.delete();
        ref_pri_y = 1'b0;
        @(negedge clk);
        check_bit("post_rst_x_wins", x_gnt, 1'b1);
        model_step();
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 1, 0, 'h90, 0);
        run_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) run_cycle();

        // Random traffic over a few shared addresses to provoke conflicts.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'(16'h80 + $urandom_range(0, 3)), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'(16'h80 + $urandom_range(0, 3)), 16'($urandom));
            run_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) run_cycle();
        check_bit("drain_x_empty", qx.size() == 0, 1'b1);
        check_bit("drain_y_empty", qy.size() == 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
